// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes (a - b - bin) mod 2^N and the
// borrow out, one bit per clock, LSB first, with a start/done handshake.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   start  in   1  request; accepted only in IDLE or DONE
//   a      in   N  minuend, captured on an accepted start
//   b      in   N  subtrahend, captured on an accepted start
//   bin    in   1  borrow in, captured on an accepted start
//   busy   out  1  high while an operation is in RUN
//   done   out  1  one-cycle pulse when diff/bout are updated
//   diff   out  N  (a - b - bin) mod 2^N, held until the next completion
//   bout   out  1  borrow out, 1 iff a < b + bin
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   work_r;
    logic [N-1:0]   diff_r;
    logic [CW-1:0]  count_r;
    logic           borrow_r;
    logic           bout_r;
    logic           busy_r;
    logic           done_r;

    logic           d_s;
    logic           borrow_next_s;
    logic [N-1:0]   work_next_s;

    // Single-bit difference of a full subtractor.
    function automatic logic sub_diff_bit(input logic x, input logic y, input logic bw);
        return x ^ y ^ bw;
    endfunction

    // Borrow generated by x - y - bw: borrow when x=0,y=1, or x==y with a borrow pending.
    function automatic logic sub_borrow_bit(input logic x, input logic y, input logic bw);
        return (~x & y) | (~(x ^ y) & bw);
    endfunction

    // Per-cycle bit-serial datapath: current difference bit, next borrow, next working word.
    always_comb begin
        d_s           = sub_diff_bit(a_r[0], b_r[0], borrow_r);
        borrow_next_s = sub_borrow_bit(a_r[0], b_r[0], borrow_r);
        // New difference bit enters at the MSB so that after N shifts bit 0 lands at LSB.
        work_next_s        = work_r >> 1'b1;
        work_next_s[N-1]   = d_s;
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            work_r   <= '0;
            diff_r   <= '0;
            count_r  <= '0;
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                // DONE accepts a new start exactly like IDLE, giving back-to-back throughput.
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        borrow_r <= bin;
                        count_r  <= '0;
                        work_r   <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                // start is deliberately not looked at here.
                ST_RUN: begin
                    a_r      <= a_r >> 1'b1;
                    b_r      <= b_r >> 1'b1;
                    borrow_r <= borrow_next_s;
                    work_r   <= work_next_s;
                    count_r  <= count_r + CW'(1);
                    if (count_r == LAST_COUNT) begin
                        diff_r  <= work_next_s;
                        bout_r  <= borrow_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule
